sram_port_arbiter: RTL and testbench

- Shares the single external SRAM port among three requesters:
  - req 0: UART loader
  - req 1: decode/compute datapath
  - req 2: VGA frame reader
- Round-robin arbitration with bounded bursts and a one-cycle bus turnaround between owners.
- Drives the SRAM controller's address, write-data and we_n.
- Returns read data to the owner, with a per-requester valid strobe aligned to the SRAM read latency.

---
 rtl/sram_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM controller port among three requesters.
// Optional `ARB_UART_PRIORITY_EN gives requester 0 absolute priority.
module sram_port_arbiter #(
    parameter int NREQ      = 3,
    parameter int MAX_BURST = 16,
    parameter int RD_LAT    = 3
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic [NREQ-1:0]      Req,
    input  logic [18*NREQ-1:0]   Req_address,
    input  logic [16*NREQ-1:0]   Req_write_data,
    input  logic [NREQ-1:0]      Req_we_n,
    output logic [NREQ-1:0]      Grant,
    output logic [NREQ-1:0]      Rd_valid,
    output logic [15:0]          Rd_data,
    input  logic [15:0]          SRAM_read_data,
    output logic [17:0]          SRAM_address,
    output logic [15:0]          SRAM_write_data,
    output logic                 SRAM_we_n
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        S_ARB_IDLE   = 2'd0,
        S_ARB_OWN    = 2'd1,
        S_ARB_SWITCH = 2'd2
    } state_t;

    state_t             r_state;
    logic [1:0]         r_owner;
    logic [1:0]         r_rr;
    logic [BW-1:0]      r_burst;
    logic [NREQ-1:0]    r_grant;
    logic               r_tag_vld [0:RD_LAT];
    logic [1:0]         r_tag_id  [0:RD_LAT];

    logic [17:0]        w_mux_addr;
    logic [15:0]        w_mux_wdata;
    logic               w_mux_we_n;
    logic               w_accept;
    logic               w_others;
    logic               w_burst_done;
    logic               w_preempt;
    logic [1:0]         w_pick;
    logic [1:0]         w_next_rr;

    function automatic logic [1:0] f_wrap(input logic [2:0] x);
        f_wrap = (x >= 3'd3) ? 2'(x - 3'd3) : x[1:0];
    endfunction

    function automatic logic [2:0] f_oh(input logic [1:0] idx);
        f_oh = 3'b001 << idx;
    endfunction

    // First requesting index scanning upward from start, modulo 3.
    function automatic logic [1:0] f_pick(input logic [2:0] req, input logic [1:0] start);
        logic [1:0] idx;
        f_pick = start;
        for (int k = 2; k >= 0; k--) begin
            idx = f_wrap({1'b0, start} + 3'(k));
            if (req[idx]) f_pick = idx;
        end
`ifdef ARB_UART_PRIORITY_EN
        if (req[0]) f_pick = 2'd0;
`endif
    endfunction

    always_comb begin
        w_mux_addr  = '0;
        w_mux_wdata = '0;
        w_mux_we_n  = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_mux_addr  = Req_address[18*i +: 18];
                w_mux_wdata = Req_write_data[16*i +: 16];
                w_mux_we_n  = Req_we_n[i];
            end
        end
    end

    // Grant is only non-zero in S_ARB_OWN, so it doubles as the owner mask.
    assign w_accept  = (r_state == S_ARB_OWN) && |(r_grant & Req);
    assign w_others  = |(Req & ~r_grant);
    assign w_pick    = f_pick(Req, r_rr);
    assign w_next_rr = f_wrap({1'b0, r_owner} + 3'd1);

`ifdef ARB_UART_PRIORITY_EN
    assign w_burst_done = (r_burst >= BURST_LAST) && (r_owner != 2'd0);
    assign w_preempt    = (r_owner != 2'd0) && Req[0];
`else
    assign w_burst_done = (r_burst >= BURST_LAST);
    assign w_preempt    = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_ARB_IDLE;
            r_owner <= 2'd0;
            r_rr    <= 2'd0;
            r_burst <= '0;
            r_grant <= '0;
        end else begin
            case (r_state)
                S_ARB_IDLE, S_ARB_SWITCH: begin
                    if (|Req) begin
                        r_owner <= w_pick;
                        r_grant <= f_oh(w_pick);
                        r_burst <= '0;
                        r_state <= S_ARB_OWN;
                    end else begin
                        r_grant <= '0;
                        r_state <= S_ARB_IDLE;
                    end
                end
                S_ARB_OWN: begin
                    if (w_accept && (r_burst != BURST_MAX))
                        r_burst <= r_burst + 1'b1;
                    if (!w_accept) begin
                        r_grant <= '0;
                        if (w_others) begin
                            r_rr    <= w_next_rr;
                            r_state <= S_ARB_SWITCH;
                        end else begin
                            r_state <= S_ARB_IDLE;
                        end
                    end else if (w_preempt || (w_burst_done && w_others)) begin
                        // Last access of this tenure is still accepted at this edge.
                        r_grant <= '0;
                        r_rr    <= w_next_rr;
                        r_state <= S_ARB_SWITCH;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= S_ARB_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
        end else if (w_accept) begin
            SRAM_address    <= w_mux_addr;
            SRAM_write_data <= w_mux_wdata;
            SRAM_we_n       <= w_mux_we_n;
        end else begin
            SRAM_we_n       <= 1'b1;
        end
    end

    // Read tags drain regardless of arbitration state so ownership changes lose nothing.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 0; k <= RD_LAT; k++) begin
                r_tag_vld[k] <= 1'b0;
                r_tag_id[k]  <= 2'd0;
            end
            Rd_valid <= '0;
            Rd_data  <= '0;
        end else begin
            r_tag_vld[0] <= w_accept && w_mux_we_n;
            r_tag_id[0]  <= r_owner;
            for (int k = 1; k <= RD_LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
            Rd_valid <= r_tag_vld[RD_LAT] ? f_oh(r_tag_id[RD_LAT]) : '0;
            Rd_data  <= SRAM_read_data;
        end
    end

    assign Grant = r_grant;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus random traffic
// against a tenure-level arbitration model and a ROM-backed SRAM model.
module tb_sram_port_arbiter;

    localparam int MAXB = 16;
    localparam int RDL  = 3;
`ifdef ARB_UART_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [2:0]  Req;
    logic [53:0] Req_address;
    logic [47:0] Req_write_data;
    logic [2:0]  Req_we_n;
    logic [2:0]  Grant;
    logic [2:0]  Rd_valid;
    logic [15:0] Rd_data;
    logic [15:0] SRAM_read_data;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    sram_port_arbiter #(.NREQ(3), .MAX_BURST(MAXB), .RD_LAT(RDL)) dut (
        .Clock(Clock), .Resetn(Resetn), .Req(Req), .Req_address(Req_address),
        .Req_write_data(Req_write_data), .Req_we_n(Req_we_n), .Grant(Grant),
        .Rd_valid(Rd_valid), .Rd_data(Rd_data), .SRAM_read_data(SRAM_read_data),
        .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
        .SRAM_we_n(SRAM_we_n)
    );

    always #5 Clock = ~Clock;

    // SRAM content is a fixed function of address; data returns RDL cycles after the address.
    function automatic logic [15:0] romf(input logic [17:0] ad);
        return (ad[15:0] ^ 16'h5A3C) + {14'd0, ad[17:16]};
    endfunction

    logic [17:0] hist [RDL] = '{default: 18'd0};
    always @(posedge Clock) begin
        hist[0] <= SRAM_address;
        for (int k = 1; k < RDL; k++) hist[k] <= hist[k-1];
    end
    assign SRAM_read_data = romf(hist[RDL-1]);

    typedef struct { int due; int id; logic [17:0] ad; } rd_t;
    rd_t pend[$];

    logic [17:0] a    [3];
    logic        w    [3];
    logic [15:0] d    [3];
    int          left [3];
    int own, cnt, ptr, cyc;
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r);
        if (PRIO && r[0]) return 0;
        for (int k = 0; k < 3; k++)
            if (r[(ptr + k) % 3]) return (ptr + k) % 3;
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            Req[i]                     = (left[i] > 0);
            Req_address[18*i +: 18]    = a[i];
            Req_write_data[16*i +: 16] = d[i];
            Req_we_n[i]                = w[i];
        end
    endtask

    task automatic start(input int i, input logic [17:0] ad, input logic we, input int n, input logic [15:0] wd);
        a[i] = ad; w[i] = we; left[i] = n; d[i] = wd;
        drive();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) left[i] = 0;
        drive();
        own = -1; cnt = 0; ptr = 0;
        pend.delete();
    endtask

    // One clock: predict the edge from current requests, then compare outputs after it.
    task automatic step();
        logic [2:0]  r, eg, erv;
        logic [17:0] ead;
        logic [15:0] ewd, erd;
        logic        ewe;
        int          ga, g;
        bit          others;
        rd_t         e;
        r = Req; ga = -1;
        if (own < 0) begin
            if (r != 3'b000) begin own = pick(r); cnt = 0; end
        end else begin
            g = own;
            others = (r & ~(3'b001 << g)) != 3'b000;
            if (r[g]) ga = g;
            if (!r[g]) begin
                own = -1;
                if (others) ptr = (g + 1) % 3;
            end else if ((PRIO && g != 0 && r[0]) ||
                         (!(PRIO && g == 0) && cnt >= MAXB - 1 && others)) begin
                own = -1;
                ptr = (g + 1) % 3;
            end
            if (r[g]) cnt++;
        end
        eg = (own < 0) ? 3'b000 : 3'(3'b001 << own);
        if (ga >= 0) begin ewe = w[ga]; ead = a[ga]; ewd = d[ga]; end
        else begin ewe = 1'b1; ead = '0; ewd = '0; end
        @(posedge Clock); cyc++; #1;
        chk("grant", 32'(Grant), 32'(eg));
        chk("sram_we_n", 32'(SRAM_we_n), 32'(ewe));
        if (ga >= 0) begin
            chk("sram_addr", 32'(SRAM_address), 32'(ead));
            if (!ewe) chk("sram_wdata", 32'(SRAM_write_data), 32'(ewd));
            if (ewe) begin
                e.due = cyc + RDL + 1; e.id = ga; e.ad = ead;
                pend.push_back(e);
            end
            a[ga]++; d[ga]++; left[ga]--;
        end
        erv = 3'b000; erd = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            erv = 3'(3'b001 << pend[0].id);
            erd = romf(pend[0].ad);
            void'(pend.pop_front());
        end
        chk("rd_valid", 32'(Rd_valid), 32'(erv));
        if (erv != 3'b000) chk("rd_data", 32'(Rd_data), 32'(erd));
        drive();
    endtask

    task automatic run_quiet(input int limit);
        int n;
        n = 0;
        while ((left[0] + left[1] + left[2] > 0 || own >= 0 || pend.size() > 0) && n < limit) begin
            step();
            n++;
        end
        chk("quiet_timeout", 32'(n < limit), 32'd1);
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        model_reset();
        @(posedge Clock); #1;
        Resetn = 1'b1;
    endtask

    initial begin
        Resetn = 1'b0;
        Req = '0; Req_address = '0; Req_write_data = '0; Req_we_n = '1;
        for (int i = 0; i < 3; i++) begin a[i] = '0; w[i] = 1'b1; d[i] = '0; left[i] = 0; end
        own = -1; cnt = 0; ptr = 0; cyc = 0;
        @(posedge Clock); #1;
        chk("rst_grant", 32'(Grant), 32'd0);
        chk("rst_rd_valid", 32'(Rd_valid), 32'd0);
        chk("rst_rd_data", 32'(Rd_data), 32'd0);
        chk("rst_sram_addr", 32'(SRAM_address), 32'd0);
        chk("rst_sram_wdata", 32'(SRAM_write_data), 32'd0);
        chk("rst_sram_we_n", 32'(SRAM_we_n), 32'd1);
        Resetn = 1'b1;

        // UART loader writes four words at 76800.
        start(0, 18'd76800, 1'b0, 4, 16'hA5A5);
        step();
        chk("t1_first_grant", 32'(Grant), 32'b001);
        run_quiet(50);

        // Simultaneous 1 and 2 from reset: 1 first for 16, switch cycle, then 2 reads 0..7.
        do_reset();
        start(1, 18'h00100, 1'b1, 20, 16'h0);
        start(2, 18'h00000, 1'b1, 8, 16'h0);
        step();
        chk("t2_first_owner", 32'(Grant), 32'b010);
        repeat (16) step();
        chk("t2_switch_gap", 32'(Grant), 32'b000);
        step();
        chk("t2_second_owner", 32'(Grant), 32'b100);
        run_quiet(200);

        // Requester 1 read burst ends with reads in flight; requester 0 writes next.
        start(1, 18'h00200, 1'b1, 6, 16'h0);
        repeat (3) step();
        start(0, 18'h00300, 1'b0, 3, 16'h7000);
        run_quiet(100);

        // Reset in the middle of a write burst at address 100.
        start(0, 18'd100, 1'b0, 10, 16'h1234);
        repeat (4) step();
        #3 Resetn = 1'b0;
        #1;
        chk("midrst_grant", 32'(Grant), 32'd0);
        chk("midrst_we_n", 32'(SRAM_we_n), 32'd1);
        chk("midrst_rd_valid", 32'(Rd_valid), 32'd0);
        chk("midrst_addr", 32'(SRAM_address), 32'd0);
        model_reset();
        @(posedge Clock); #1;
        Resetn = 1'b1;
        start(2, 18'h00040, 1'b1, 2, 16'h0);
        start(0, 18'h00050, 1'b1, 2, 16'h0);
        step();
        chk("midrst_ptr_zero", 32'(Grant), 32'b001);
        run_quiet(100);

        // Requester 2 owns when requester 0 arrives.
        start(2, 18'h00400, 1'b1, 24, 16'h0);
        repeat (3) step();
        start(0, 18'h00500, 1'b0, 4, 16'hBEEF);
        run_quiet(200);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 3; i++)
                if (left[i] == 0 && $urandom_range(7) == 0)
                    start(i, 18'($urandom), 1'($urandom_range(1)),
                          int'($urandom_range(24, 1)), 16'($urandom));
            step();
        end
        run_quiet(500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
